// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the control_sequencer slice.
//   - OPW / CTRLW widths, opcode constants, FSM state enum
//   - bit positions of every strobe inside the packed ctrl word
//   - opcode classification and fetch/execute step helpers
package ctrl_pkg;

    localparam int OPW   = 5;
    localparam int CTRLW = 26;

    localparam logic [OPW-1:0] OP_LD   = 5'd0;
    localparam logic [OPW-1:0] OP_LDI  = 5'd1;
    localparam logic [OPW-1:0] OP_ST   = 5'd2;
    localparam logic [OPW-1:0] OP_ADD  = 5'd3;
    localparam logic [OPW-1:0] OP_SHL  = 5'd11;
    localparam logic [OPW-1:0] OP_ADDI = 5'd12;
    localparam logic [OPW-1:0] OP_ORI  = 5'd14;
    localparam logic [OPW-1:0] OP_DIV  = 5'd15;
    localparam logic [OPW-1:0] OP_MUL  = 5'd16;
    localparam logic [OPW-1:0] OP_NEG  = 5'd17;
    localparam logic [OPW-1:0] OP_NOT  = 5'd18;
    localparam logic [OPW-1:0] OP_NOP  = 5'd26;
    localparam logic [OPW-1:0] OP_HALT = 5'd27;

    typedef enum logic [3:0] {
        ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } state_t;

    typedef enum logic [3:0] {
        CL_RTYPE, CL_IMM, CL_MULDIV, CL_UNARY, CL_LD, CL_LDI, CL_ST,
        CL_NOP, CL_HALT, CL_ILLEGAL
    } op_class_t;

    localparam int CTRL_PCOUT     = 0;
    localparam int CTRL_MARIN     = 1;
    localparam int CTRL_INCPC     = 2;
    localparam int CTRL_READ      = 3;
    localparam int CTRL_WRITE     = 4;
    localparam int CTRL_MDRIN     = 5;
    localparam int CTRL_MDROUT    = 6;
    localparam int CTRL_IRIN      = 7;
    localparam int CTRL_YIN       = 8;
    localparam int CTRL_ZHIGHIN   = 9;
    localparam int CTRL_ZLOWIN    = 10;
    localparam int CTRL_ZHIGHOUT  = 11;
    localparam int CTRL_ZLOWOUT   = 12;
    localparam int CTRL_HIIN      = 13;
    localparam int CTRL_LOIN      = 14;
    localparam int CTRL_HIOUT     = 15;
    localparam int CTRL_LOOUT     = 16;
    localparam int CTRL_CSIGNOUT  = 17;
    localparam int CTRL_GRA       = 18;
    localparam int CTRL_GRB       = 19;
    localparam int CTRL_GRC       = 20;
    localparam int CTRL_RIN       = 21;
    localparam int CTRL_ROUT      = 22;
    localparam int CTRL_BAOUT     = 23;
    localparam int CTRL_INPORTOUT = 24;
    localparam int CTRL_PCIN      = 25;

    function automatic op_class_t classify(input logic [OPW-1:0] op);
        if (op == OP_LD)                        return CL_LD;
        else if (op == OP_LDI)                  return CL_LDI;
        else if (op == OP_ST)                   return CL_ST;
        else if (op >= OP_ADD && op <= OP_SHL)  return CL_RTYPE;
        else if (op >= OP_ADDI && op <= OP_ORI) return CL_IMM;
        else if (op == OP_DIV || op == OP_MUL)  return CL_MULDIV;
        else if (op == OP_NEG || op == OP_NOT)  return CL_UNARY;
        else if (op == OP_NOP)                  return CL_NOP;
        else if (op == OP_HALT)                 return CL_HALT;
        else                                    return CL_ILLEGAL;
    endfunction

    // Sequential successor of a step that is neither waiting nor final.
    function automatic state_t next_step(input state_t s);
        case (s)
            ST_T0:   return ST_T1;
            ST_T1:   return ST_T2;
            ST_T2:   return ST_T3;
            ST_T3:   return ST_T4;
            ST_T4:   return ST_T5;
            ST_T5:   return ST_T6;
            ST_T6:   return ST_T7;
            default: return ST_T0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational step decoder (state + opcode -> strobes).
//   state     in   current FSM state
//   opcode    in   IR[31:27]
//   ctrl      out  packed datapath strobes
//   alu_op    out  ALU opcode (meaningful while ZLowIn/ZHighIn is set)
//   illegal   out  unsupported opcode seen in T3
//   run       out  0 only in HALT
//   last      out  this step is the final execute step of the instruction
//   halt_op   out  halt opcode reached its final step
//   mem_state out  step waits on a memory handshake
module ctrl_decode
    import ctrl_pkg::*;
(
    input  state_t           state,
    input  logic [OPW-1:0]   opcode,
    output logic [CTRLW-1:0] ctrl,
    output logic [OPW-1:0]   alu_op,
    output logic             illegal,
    output logic             run,
    output logic             last,
    output logic             halt_op,
    output logic             mem_state
);

    op_class_t cls;
    assign cls = classify(opcode);

    always_comb begin
        ctrl      = '0;
        alu_op    = '0;
        illegal   = 1'b0;
        run       = 1'b1;
        last      = 1'b0;
        halt_op   = 1'b0;
        mem_state = 1'b0;
        case (state)
            ST_HALT: run = 1'b0;
            ST_T0: begin
                ctrl[CTRL_PCOUT] = 1'b1; ctrl[CTRL_MARIN] = 1'b1; ctrl[CTRL_INCPC] = 1'b1;
            end
            ST_T1: begin
                ctrl[CTRL_READ] = 1'b1; ctrl[CTRL_MDRIN] = 1'b1; mem_state = 1'b1;
            end
            ST_T2: begin
                ctrl[CTRL_MDROUT] = 1'b1; ctrl[CTRL_IRIN] = 1'b1;
            end
            ST_T3: begin
                case (cls)
                    CL_RTYPE, CL_IMM: begin
                        ctrl[CTRL_GRB] = 1'b1; ctrl[CTRL_ROUT] = 1'b1; ctrl[CTRL_YIN] = 1'b1;
                    end
                    CL_MULDIV: begin
                        ctrl[CTRL_GRA] = 1'b1; ctrl[CTRL_ROUT] = 1'b1; ctrl[CTRL_YIN] = 1'b1;
                    end
                    CL_UNARY: begin
                        ctrl[CTRL_GRB] = 1'b1; ctrl[CTRL_ROUT] = 1'b1; ctrl[CTRL_ZLOWIN] = 1'b1;
                        alu_op = opcode;
                    end
                    CL_LD, CL_LDI, CL_ST: begin
                        ctrl[CTRL_GRB] = 1'b1; ctrl[CTRL_BAOUT] = 1'b1; ctrl[CTRL_YIN] = 1'b1;
                    end
                    CL_HALT: begin
                        last = 1'b1; halt_op = 1'b1;
                    end
                    CL_ILLEGAL: begin
                        last = 1'b1; illegal = 1'b1;
                    end
                    default: last = 1'b1;
                endcase
            end
            ST_T4: begin
                case (cls)
                    CL_RTYPE: begin
                        ctrl[CTRL_GRC] = 1'b1; ctrl[CTRL_ROUT] = 1'b1; ctrl[CTRL_ZLOWIN] = 1'b1;
                        alu_op = opcode;
                    end
                    CL_IMM: begin
                        ctrl[CTRL_CSIGNOUT] = 1'b1; ctrl[CTRL_ZLOWIN] = 1'b1; alu_op = opcode;
                    end
                    CL_MULDIV: begin
                        ctrl[CTRL_GRB] = 1'b1; ctrl[CTRL_ROUT] = 1'b1;
                        ctrl[CTRL_ZHIGHIN] = 1'b1; ctrl[CTRL_ZLOWIN] = 1'b1;
                        alu_op = opcode;
                    end
                    CL_UNARY: begin
                        ctrl[CTRL_ZLOWOUT] = 1'b1; ctrl[CTRL_GRA] = 1'b1; ctrl[CTRL_RIN] = 1'b1;
                        last = 1'b1;
                    end
                    // Address arithmetic is always an add, whatever the opcode says.
                    CL_LD, CL_LDI, CL_ST: begin
                        ctrl[CTRL_CSIGNOUT] = 1'b1; ctrl[CTRL_ZLOWIN] = 1'b1; alu_op = OP_ADD;
                    end
                    default: last = 1'b1;
                endcase
            end
            ST_T5: begin
                case (cls)
                    CL_RTYPE, CL_IMM, CL_LDI: begin
                        ctrl[CTRL_ZLOWOUT] = 1'b1; ctrl[CTRL_GRA] = 1'b1; ctrl[CTRL_RIN] = 1'b1;
                        last = 1'b1;
                    end
                    CL_MULDIV: begin
                        ctrl[CTRL_ZLOWOUT] = 1'b1; ctrl[CTRL_LOIN] = 1'b1;
                    end
                    CL_LD, CL_ST: begin
                        ctrl[CTRL_ZLOWOUT] = 1'b1; ctrl[CTRL_MARIN] = 1'b1;
                    end
                    default: last = 1'b1;
                endcase
            end
            ST_T6: begin
                case (cls)
                    CL_MULDIV: begin
                        ctrl[CTRL_ZHIGHOUT] = 1'b1; ctrl[CTRL_HIIN] = 1'b1; last = 1'b1;
                    end
                    CL_LD: begin
                        ctrl[CTRL_READ] = 1'b1; ctrl[CTRL_MDRIN] = 1'b1; mem_state = 1'b1;
                    end
                    CL_ST: begin
                        ctrl[CTRL_GRA] = 1'b1; ctrl[CTRL_ROUT] = 1'b1; ctrl[CTRL_MDRIN] = 1'b1;
                    end
                    default: last = 1'b1;
                endcase
            end
            ST_T7: begin
                last = 1'b1;
                case (cls)
                    CL_LD: begin
                        ctrl[CTRL_MDROUT] = 1'b1; ctrl[CTRL_GRA] = 1'b1; ctrl[CTRL_RIN] = 1'b1;
                    end
                    CL_ST: begin
                        ctrl[CTRL_WRITE] = 1'b1; mem_state = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit driving the CPU datapath.
//   clock     in   rising-edge clock
//   clear     in   synchronous active-high reset (to RST, drops pending memory ops)
//   IR        in   instruction register, opcode in IR[31:27]
//   mem_ready in   memory completed the current Read/Write
//   stop      in   halt at the next instruction boundary
//   ctrl      out  packed datapath strobes (layout in ctrl_pkg)
//   alu_op    out  ALU opcode
//   run       out  1 while executing, 0 when halted
//   illegal   out  one-cycle pulse in T3 for unsupported opcodes
// Build option MEM_HANDSHAKE_EN: when defined, memory steps (T1, ld T6, st T7)
// hold until mem_ready; otherwise each memory step lasts exactly one cycle.
module control_sequencer
    import ctrl_pkg::*;
(
    input  logic             clock,
    input  logic             clear,
    input  logic [31:0]      IR,
    input  logic             mem_ready,
    input  logic             stop,
    output logic [CTRLW-1:0] ctrl,
    output logic [OPW-1:0]   alu_op,
    output logic             run,
    output logic             illegal
);

`ifdef MEM_HANDSHAKE_EN
    localparam bit HANDSHAKE = 1'b1;
`else
    localparam bit HANDSHAKE = 1'b0;
`endif

    state_t      state;
    logic        last;
    logic        halt_op;
    logic        mem_state;
    logic        hold;
    logic [26:0] operand_unused;

    // Register fields are expanded in the datapath; only the opcode matters here.
    assign operand_unused = IR[26:0];
    assign hold = HANDSHAKE & mem_state & ~mem_ready;

    ctrl_decode u_decode (
        .state     (state),
        .opcode    (IR[31:27]),
        .ctrl      (ctrl),
        .alu_op    (alu_op),
        .illegal   (illegal),
        .run       (run),
        .last      (last),
        .halt_op   (halt_op),
        .mem_state (mem_state)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= ST_RST;
        end else begin
            case (state)
                ST_RST:  state <= ST_T0;
                ST_HALT: state <= ST_HALT;
                default: begin
                    if (hold)
                        state <= state;
                    else if (last)
                        state <= (stop || halt_op) ? ST_HALT : ST_T0;
                    else
                        state <= next_step(state);
                end
            endcase
        end
    end

endmodule
